// File: rtl/draw_player_if.sv
// VGA timing bundle plus pixel colour, passed between pipeline stages.
interface draw_player_if;
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// Player-square overlay: moves the square once per frame inside the arena and paints it.
// Optional PLAYER_ACCEL_EN doubles the step after 15 consecutive pressed frame ticks.
module draw_player #(
    parameter int unsigned TOP_V_LINE    = 367,
    parameter int unsigned BOTTOM_V_LINE = 667,
    parameter int unsigned LEFT_H_LINE   = 361,
    parameter int unsigned RIGHT_H_LINE  = 661,
    parameter int unsigned SIZE          = 16,
    parameter int unsigned STEP          = 2,
    parameter logic [11:0] COLOR         = 12'hf_0_f
) (
    input  logic         pclk,
    input  logic         rst,
    draw_player_if.slave  vga_in,
    draw_player_if.master vga_out,
    input  logic         mouse_mode,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    output logic [11:0]  player_x,
    output logic [11:0]  player_y
);

    localparam logic [12:0] SPAWN_X = 13'((LEFT_H_LINE + RIGHT_H_LINE - SIZE) / 2);
    localparam logic [12:0] SPAWN_Y = 13'((TOP_V_LINE + BOTTOM_V_LINE - SIZE) / 2);
    localparam logic [12:0] X_MIN   = 13'(LEFT_H_LINE);
    localparam logic [12:0] X_MAX   = 13'(RIGHT_H_LINE - SIZE);
    localparam logic [12:0] Y_MIN   = 13'(TOP_V_LINE);
    localparam logic [12:0] Y_MAX   = 13'(BOTTOM_V_LINE - SIZE);
    localparam logic [12:0] SIZE_W  = 13'(SIZE);

    typedef enum logic {StIdle, StPlay} state_t;

    state_t      state_q, state_d;
    logic [11:0] x_q, y_q;
    logic [12:0] x_d, y_d;
    logic        vblnk_q;
    logic        tick;
    logic        hit;
    logic [11:0] rgb_nxt;
    logic [12:0] step;

    assign tick = vga_in.vblnk & ~vblnk_q;

`ifdef PLAYER_ACCEL_EN
    logic [3:0] cnt_q, cnt_d;

    assign step = (cnt_q == 4'hf) ? 13'(2 * STEP) : 13'(STEP);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle || !mouse_mode) begin
            cnt_d = 4'h0;
        end else if (tick) begin
            if (btn_up | btn_down | btn_left | btn_right) begin
                cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'h1;
            end else begin
                cnt_d = 4'h0;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) cnt_q <= 4'h0;
        else      cnt_q <= cnt_d;
    end
`else
    assign step = 13'(STEP);
`endif

    // One axis: opposing or absent requests hold; otherwise step and clamp to [lo, hi].
    function automatic logic [12:0] move(input logic [12:0] pos, input logic inc,
                                         input logic dec, input logic [12:0] stp,
                                         input logic [12:0] lo, input logic [12:0] hi);
        logic [12:0] res;
        res = pos;
        if (inc && !dec) res = (pos + stp > hi) ? hi : pos + stp;
        else if (dec && !inc) res = (pos < lo + stp) ? lo : pos - stp;
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = {1'b0, x_q};
        y_d     = {1'b0, y_q};
        unique case (state_q)
            StIdle: begin
                x_d = SPAWN_X;
                y_d = SPAWN_Y;
                if (mouse_mode) state_d = StPlay;
            end
            StPlay: begin
                if (!mouse_mode) begin
                    state_d = StIdle;
                    x_d     = SPAWN_X;
                    y_d     = SPAWN_Y;
                end else if (tick) begin
                    x_d = move({1'b0, x_q}, btn_right, btn_left, step, X_MIN, X_MAX);
                    y_d = move({1'b0, y_q}, btn_down, btn_up, step, Y_MIN, Y_MAX);
                end
            end
        endcase
    end

    assign hit = ({1'b0, vga_in.hcount} >= {1'b0, x_q}) &&
                 ({1'b0, vga_in.hcount} <  {1'b0, x_q} + SIZE_W) &&
                 ({1'b0, vga_in.vcount} >= {1'b0, y_q}) &&
                 ({1'b0, vga_in.vcount} <  {1'b0, y_q} + SIZE_W);

    always_comb begin
        rgb_nxt = vga_in.rgb;
        if (vga_in.hblnk || vga_in.vblnk) rgb_nxt = 12'h000;
        else if (state_q == StPlay && hit) rgb_nxt = COLOR;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            x_q            <= SPAWN_X[11:0];
            y_q            <= SPAWN_Y[11:0];
            vblnk_q        <= 1'b0;
            vga_out.vcount <= 12'h000;
            vga_out.hcount <= 12'h000;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= 12'h000;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d[11:0];
            y_q            <= y_d[11:0];
            vblnk_q        <= vga_in.vblnk;
            vga_out.vcount <= vga_in.vcount;
            vga_out.hcount <= vga_in.hcount;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.rgb    <= rgb_nxt;
        end
    end

    assign player_x = x_q;
    assign player_y = y_q;

endmodule

// File: tb/tb_draw_player.sv
// Directed bench for draw_player: reset, menu pass-through, movement, clamping, compositing.
module tb_draw_player;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    logic mouse_mode, btn_up, btn_down, btn_left, btn_right;
    logic [11:0] player_x, player_y;

    draw_player_if vin ();
    draw_player_if vout ();

    draw_player dut (
        .pclk       (pclk),
        .rst        (rst),
        .vga_in     (vin),
        .vga_out    (vout),
        .mouse_mode (mouse_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .player_x   (player_x),
        .player_y   (player_y)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hblnk, vblnk, hsync, vsync;
        logic [11:0] h, v, rgb, exp_rgb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    // b = {up, down, left, right}; one rising edge of vblnk with buttons, then one idle cycle
    task automatic tick(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
        vin.vblnk = 1'b1;
        cyc();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        vin.vblnk = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic chk_pos(input string name, input logic [11:0] ex, input logic [11:0] ey);
        chk({name, "_x"}, {20'h0, player_x}, {20'h0, ex});
        chk({name, "_y"}, {20'h0, player_y}, {20'h0, ey});
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_vcount"}, {20'h0, vout.vcount}, 32'd0);
        chk({name, "_hcount"}, {20'h0, vout.hcount}, 32'd0);
        chk({name, "_syncs"}, {28'h0, vout.vsync, vout.vblnk, vout.hsync, vout.hblnk}, 32'd0);
        chk({name, "_rgb"}, {20'h0, vout.rgb}, 32'd0);
        chk_pos(name, 12'd503, 12'd509);
    endtask

    vec_t vecs [10];
    bit   in_range;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Square at (523,509) after the right-move phase: covers h 523..538, v 509..524
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'd523, 12'd509, 12'h123, 12'hf0f};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd538, 12'd524, 12'h234, 12'hf0f};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd539, 12'd509, 12'h456, 12'h456};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd522, 12'd509, 12'h567, 12'h567};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd523, 12'd525, 12'h678, 12'h678};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'd530, 12'd508, 12'h789, 12'h789};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd530, 12'd515, 12'habc, 12'hf0f};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'd530, 12'd515, 12'habc, 12'h000};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd530, 12'd515, 12'habc, 12'h000};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd100, 12'd100, 12'hdef, 12'hdef};

        mouse_mode = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        vin.vcount = 12'd100; vin.hcount = 12'd200; vin.rgb = 12'hfff;
        vin.vsync = 1'b1; vin.hsync = 1'b1; vin.vblnk = 1'b0; vin.hblnk = 1'b0;

        // Reset held: everything at reset values despite busy inputs
        repeat (3) cyc();
        chk_zero_outputs("reset");

        rst = 1'b1;
        cyc();

        // Menu mode: pure 1-cycle pass-through across and around the spawn square
        for (int v = 505; v <= 530; v++) begin
            for (int h = 499; h <= 524; h++) begin
                vin.hcount = 12'(h);
                vin.vcount = 12'(v);
                vin.rgb    = {6'(h), 6'(v)};
                vin.hsync  = h[0];
                vin.vsync  = v[0];
                cyc();
                chk("menu_rgb", {20'h0, vout.rgb}, {20'h0, 6'(h), 6'(v)});
                chk("menu_hcount", {20'h0, vout.hcount}, 32'(h));
                chk("menu_vcount", {20'h0, vout.vcount}, 32'(v));
                chk("menu_syncs", {30'h0, vout.hsync, vout.vsync}, {30'h0, h[0], v[0]});
            end
        end
        chk_pos("menu", 12'd503, 12'd509);

        // Game mode: move right 10 ticks
        mouse_mode = 1'b1;
        cyc();
        ticks(10, 4'b0001);
        chk_pos("right10", 12'd523, 12'd509);

        // Compositing and delay table
        foreach (vecs[i]) begin
            vin.hblnk = vecs[i].hblnk; vin.vblnk = vecs[i].vblnk;
            vin.hsync = vecs[i].hsync; vin.vsync = vecs[i].vsync;
            vin.hcount = vecs[i].h; vin.vcount = vecs[i].v; vin.rgb = vecs[i].rgb;
            cyc();
            chk($sformatf("vec%0d_rgb", i), {20'h0, vout.rgb}, {20'h0, vecs[i].exp_rgb});
            chk($sformatf("vec%0d_hcount", i), {20'h0, vout.hcount}, {20'h0, vecs[i].h});
            chk($sformatf("vec%0d_vcount", i), {20'h0, vout.vcount}, {20'h0, vecs[i].v});
            chk($sformatf("vec%0d_flags", i),
                {28'h0, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync},
                {28'h0, vecs[i].hblnk, vecs[i].vblnk, vecs[i].hsync, vecs[i].vsync});
        end
        vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        cyc();
        chk_pos("after_table", 12'd523, 12'd509);

        // Presses between ticks ignored; a long vblnk gives only one step
        btn_left = 1'b1;
        repeat (5) cyc();
        chk_pos("no_tick_press", 12'd523, 12'd509);
        vin.vblnk = 1'b1;
        cyc();
        chk_pos("tick_visible", 12'd521, 12'd509);
        repeat (2) cyc();
        chk_pos("long_vblnk", 12'd521, 12'd509);
        btn_left = 1'b0; vin.vblnk = 1'b0;
        cyc();

        // Left clamp: never below 361
        in_range = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(4'b0010);
            if (player_x < 12'd361) in_range = 1'b0;
        end
        chk("left_never_below", {31'h0, in_range}, 32'd1);
        chk_pos("left100", 12'd361, 12'd509);
        ticks(100, 4'b1000);
        chk_pos("up100", 12'd361, 12'd367);

        // Both horizontal held: hold; diagonal allowed
        tick(4'b0000);
        tick(4'b0001);
        chk_pos("right1", 12'd363, 12'd367);
        ticks(5, 4'b0011);
        chk_pos("both_lr", 12'd363, 12'd367);
        tick(4'b0101);
        chk_pos("diag", 12'd365, 12'd369);

        // Back to menu: spawn one cycle later
        mouse_mode = 1'b0;
        cyc();
        chk_pos("to_menu", 12'd503, 12'd509);

        // Tick coinciding with entering game mode is ignored
        mouse_mode = 1'b1; vin.vblnk = 1'b1; btn_right = 1'b1;
        cyc();
        vin.vblnk = 1'b0; btn_right = 1'b0;
        cyc();
        chk_pos("enter_tick", 12'd503, 12'd509);
        tick(4'b0001);
        chk_pos("first_move", 12'd505, 12'd509);
        // Tick coinciding with leaving game mode: spawn wins
        mouse_mode = 1'b0; vin.vblnk = 1'b1; btn_right = 1'b1;
        cyc();
        vin.vblnk = 1'b0; btn_right = 1'b0;
        chk_pos("exit_tick", 12'd503, 12'd509);
        cyc();

        // Down 20 ticks, then release resets the step
        mouse_mode = 1'b1;
        cyc();
        ticks(20, 4'b0100);
`ifdef PLAYER_ACCEL_EN
        chk_pos("down20", 12'd503, 12'd559);
        tick(4'b0000);
        tick(4'b0100);
        chk_pos("down_after_release", 12'd503, 12'd561);
`else
        chk_pos("down20", 12'd503, 12'd549);
        tick(4'b0000);
        tick(4'b0100);
        chk_pos("down_after_release", 12'd503, 12'd551);
`endif
        ticks(200, 4'b0001);
        ticks(200, 4'b0100);
        chk_pos("clamp_br", 12'd645, 12'd651);

        // Asynchronous reset during active video in game mode
        vin.hcount = 12'd650; vin.vcount = 12'd655; vin.rgb = 12'h0aa;
        vin.hsync = 1'b1; vin.vsync = 1'b1;
        cyc();
        chk("pre_reset_hit", {20'h0, vout.rgb}, 32'hf0f);
        #2 rst = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        @(posedge pclk);
        #1 rst = 1'b1;
        vin.hcount = 12'd503; vin.vcount = 12'd509; vin.rgb = 12'h0aa;
        cyc();
        chk("post_reset_idle_rgb", {20'h0, vout.rgb}, 32'h0aa);
        chk("post_reset_hcount", {20'h0, vout.hcount}, 32'd503);
        cyc();
        chk("post_reset_play_rgb", {20'h0, vout.rgb}, 32'hf0f);
        chk_pos("post_reset", 12'd503, 12'd509);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
